// File: rtl/fifo_rr_forwarder.sv
// Round-robin forwarder: pops one word at a time from four ingress queues
// and pushes it to the egress FIFO chosen by the word's two MSBs.
module fifo_rr_forwarder #(
  parameter int DATA_SIZE = 10,
  parameter int MAX_STALL = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             in_empty,
  input  logic [3:0]             in_error,
  input  logic [4*DATA_SIZE-1:0] in_data,
  input  logic [3:0]             out_pause,
  input  logic [3:0]             out_error,
  output logic [3:0]             pop,
  output logic [3:0]             push,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   stall_err,
  output logic                   error,
  output logic [7:0]             word_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [1:0]           r_grant;
  logic [1:0]           w_grant_next;
  logic [DATA_SIZE-1:0] r_hold;
  logic [DATA_SIZE-1:0] r_data_out;
  logic [3:0]           r_stall_cnt;
  logic                 r_stall_err;
  logic                 r_error;
  logic [7:0]           r_word_cnt;

  logic [DATA_SIZE-1:0] w_in_word [4];
  logic [1:0]           w_dest;
  logic                 w_paused;
  logic                 w_any_err;
  logic                 w_any_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign w_in_word[gi] = in_data[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  assign w_dest      = r_hold[DATA_SIZE-1 -: 2];
  assign w_paused    = out_pause[w_dest];
  assign w_any_err   = (|in_error) | (|out_error);
  assign w_any_ready = |(~in_empty);

  // Scan from farthest to nearest so the queue right after the last grant wins.
  always_comb begin
    w_grant_next = r_grant;
    for (int k = 4; k >= 1; k--) begin
      if (!in_empty[r_grant + 2'(k)]) w_grant_next = r_grant + 2'(k);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable && w_any_ready) w_state_next = S_POP;
      S_POP:   w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_SEND;
      S_SEND:  if (!w_paused) w_state_next = S_IDLE;
      default: w_state_next = S_ERROR;
    endcase
    if (w_any_err) w_state_next = S_ERROR;
  end

  // Strobes are masked combinationally the moment any FIFO flags an error.
  always_comb begin
    pop  = 4'b0000;
    push = 4'b0000;
    if (r_state == S_POP && !w_any_err) pop = 4'b0001 << r_grant;
    if (r_state == S_SEND && !w_paused && !w_any_err) push = 4'b0001 << w_dest;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'd3;
      r_hold      <= '0;
      r_data_out  <= '0;
      r_stall_cnt <= 4'd0;
      r_stall_err <= 1'b0;
      r_error     <= 1'b0;
      r_word_cnt  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_any_err && r_state != S_ERROR) begin
        r_error <= 1'b1;
        r_hold  <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (enable && w_any_ready) r_grant <= w_grant_next;
          S_WAIT: begin
            r_hold      <= w_in_word[r_grant];
            r_data_out  <= w_in_word[r_grant];
            r_stall_cnt <= 4'd0;
          end
          S_SEND: begin
            if (!w_paused) begin
              r_word_cnt <= r_word_cnt + 8'd1;
            end else if (r_stall_cnt != 4'(MAX_STALL)) begin
              r_stall_cnt <= r_stall_cnt + 4'd1;
              if (r_stall_cnt == 4'(MAX_STALL - 1)) r_stall_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign grant_id  = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign stall_err = r_stall_err;
  assign error     = r_error;
  assign word_cnt  = r_word_cnt;

endmodule

// File: doc/fifo_rr_forwarder.md
Name: fifo_rr_forwarder

Overview:
- Controller that sequences four input-side FIFOs (virtual-channel queues) onto four output-side FIFOs in the PCIe switch datapath.
- Picks a non-empty input queue with round-robin arbitration and pops one word from it.
- Routes the word to the output FIFO selected by its two MSBs, holding it while that FIFO reports pause (almost-full).
- Sits between the ingress FIFO bank and the egress FIFO bank. Drives their read/write strobes directly.

Parameters:
- DATA_SIZE, 10, word width; bits [DATA_SIZE-1:DATA_SIZE-2] are the destination index.
- MAX_STALL, 15, number of consecutive paused cycles in SEND before stall_err asserts; counter is 4 bits wide.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when 0, no new grant is issued; an in-flight word still completes.
- in_empty  input  4  empty flags of input FIFOs 0..3.
- in_error  input  4  error flags of input FIFOs.
- in_data  input  4*DATA_SIZE  data_out_pop of input FIFOs; queue i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- out_pause  input  4  pause (almost-full) flags of output FIFOs.
- out_error  input  4  error flags of output FIFOs.
- pop  output  4  one-hot read strobe to input FIFOs.
- push  output  4  one-hot write strobe to output FIFOs.
- data_out  output  DATA_SIZE  word presented to output FIFOs (data_in_push).
- grant_id  output  2  index of the queue currently or last granted.
- busy  output  1  high in every state except IDLE.
- stall_err  output  1  sticky; set when the stall limit is reached.
- error  output  1  sticky; set when any FIFO reports an error.
- word_cnt  output  8  count of words forwarded, wraps 255->0.

Behaviour:
- States: IDLE, POP, WAIT, SEND, ERROR.
- The state register is clocked. pop and push are decoded from state; they are never asserted simultaneously for the same word.
- Reset (reset==0, async) drives all of the following immediately:
  - state=IDLE;
  - pop=0, push=0, data_out=0;
  - grant_id=3, so queue 0 has first priority;
  - busy=0, stall_err=0, error=0, word_cnt=0, stall counter=0, hold register=0.
- Reset mid-transfer discards the held word. A pop already issued is lost; this is accepted.
- IDLE: if enable==1 and ~in_empty != 0, the grant is the first non-empty queue scanning grant_id+1, grant_id+2, ... mod 4. It is registered into grant_id, and the next state is POP. Otherwise the FSM stays in IDLE.
- POP: pop[grant_id]=1 for exactly one cycle; next state is WAIT.
- WAIT: the input FIFO presents the word on in_data this cycle. At the rising edge the slice for grant_id is captured into the hold register and stall counter=0. Next state is SEND.
- SEND:
  - data_out = hold register and dest = hold[DATA_SIZE-1:DATA_SIZE-2].
  - If out_pause[dest]==0: push[dest]=1 for this cycle, word_cnt increments, and the next state is IDLE.
  - Else: push=0, stay in SEND, and the stall counter increments, saturating at MAX_STALL.
  - stall_err is set at the edge where the counter reaches MAX_STALL. It stays set until reset; forwarding continues once pause clears.
- Throughput: 4 cycles per word (IDLE, POP, WAIT, SEND) when nothing is paused.
- Grant scan runs only in IDLE. A queue becoming empty after the grant has no effect; the pop is already committed.
- enable falling during POP, WAIT or SEND does not abort; the FSM returns to IDLE and waits there.
- Error: any bit of in_error or out_error high at a rising edge, in any non-ERROR state, causes the following:
  - next state is ERROR;
  - error=1;
  - pop and push are forced to 0 in that same cycle (combinational mask);
  - the held word is dropped.
- ERROR is terminal until reset.
- data_out holds its last value outside SEND.
- grant_id holds until the next grant.

Test Plan:
- Single word: reset low then high. Load queue 0 with 'h103, enable=1. Required: pop=4'b0001 two cycles after leaving reset, push=4'b0010 with data_out='h103 two cycles later, word_cnt=1, busy back to 0.
- Round-robin: queues 0, 1 and 3 each hold 2 words with dest 0. Required grant order 0,1,3,0,1,3; push[0] every 4 cycles; word_cnt=6; queue 2 never popped.
- Back-pressure: word 'h2A5 in queue 2, out_pause[2]=1 for 5 cycles. Required: FSM holds in SEND 5 cycles with push=0 and data_out='h2A5. push[2]=1 on the first cycle pause is low; stall_err stays 0.
- Stall limit: out_pause[1]=1 for 20 cycles with word 'h1FF pending. Required: stall_err=1 after 15 paused cycles; word pushed after pause drops; word_cnt=1.
- Error: in_error[1]=1 during WAIT. Required: next cycle state=ERROR, error=1, no push; further non-empty queues are ignored until reset.
- Async reset mid-SEND with out_pause high. Required: all outputs return to their reset values without waiting for a clk edge; after release, operation restarts with queue 0 priority.
